serial_pattern_tx: RTL and testbench

//  Transmit side of the serial bit-stream link used by the 010/101 sequence detectors.
//  - Accepts a parallel word through a ready/load handshake.
//  - Serializes the word MSB-first onto x, one bit per clk.
//  - Used as the stimulus source feeding detector FSMs in system-level and bench setups.

---
 rtl/serial_link_pkg.sv | 15 +
 rtl/pattern_predictor.sv | 42 ++++
 rtl/serial_pattern_tx.sv | 93 +++++++++
 tb/tb_serial_pattern_tx.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/serial_link_pkg.sv
// Shared types and constants for the serial pattern link (transmitter and predictor).
package serial_link_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic [2:0] PAT_010 = 3'b010;
  localparam logic [2:0] PAT_101 = 3'b101;

  localparam logic FOUND    = 1'b1;
  localparam logic NOTFOUND = 1'b0;

endpackage

// File: rtl/pattern_predictor.sv
// Two-bit history of transmitted bits and a Mealy 010/101 match, mirroring the downstream detectors.
module pattern_predictor
  import serial_link_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic bit_valid_i,
  input  logic x_i,
  output logic found_o
);

  logic [1:0] hist_q, hist_d;
  logic [1:0] fill_q, fill_d;
  logic [2:0] window;

  // fill_q saturates at 2 so the first two bits after reset can never match.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (bit_valid_i) begin
      hist_d = {hist_q[0], x_i};
      if (fill_q != 2'd2) begin
        fill_d = fill_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q <= 2'b00;
      fill_q <= 2'd0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  assign window  = {hist_q, x_i};
  assign found_o = (bit_valid_i && (fill_q == 2'd2) &&
                    ((window == PAT_010) || (window == PAT_101))) ? FOUND : NOTFOUND;

endmodule

// File: rtl/serial_pattern_tx.sv
// MSB-first serializer with ready/load handshake and pause; optional found_exp prediction
// is enabled by defining PATTERN_PREDICT_EN.
module serial_pattern_tx
  import serial_link_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  input  logic             pause,
  output logic             x,
  output logic             bit_valid,
  output logic             busy,
  output logic             done,
  output logic             found_exp
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             x_q, x_d;
  logic             advance, last_bit, accept;

  // cnt_q indexes the bit currently on x; a paused cycle neither counts nor shifts.
  assign advance   = (state_q == ST_SHIFT) && !pause;
  assign last_bit  = (cnt_q == LAST);
  assign ready     = (state_q == ST_IDLE) || (advance && last_bit);
  assign accept    = load && ready;
  assign bit_valid = advance;
  assign busy      = (state_q == ST_SHIFT);
  assign done      = advance && last_bit;
  assign x         = x_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    x_d     = x_q;
    if (accept) begin
      state_d = ST_SHIFT;
      cnt_d   = '0;
      shreg_d = data_in;
      x_d     = data_in[WIDTH-1];
    end else if (advance) begin
      if (last_bit) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        x_d     = IDLE_LEVEL;
      end else begin
        cnt_d   = cnt_q + CW'(1);
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        x_d     = shreg_q[WIDTH-2];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      x_q     <= IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
    end
  end

  // Payload shifter carries data only; its contents are irrelevant outside SHIFT.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

`ifdef PATTERN_PREDICT_EN
  pattern_predictor u_pred (
    .clk_i       (clk),
    .rst_ni      (reset),
    .bit_valid_i (bit_valid),
    .x_i         (x),
    .found_o     (found_exp)
  );
`else
  assign found_exp = NOTFOUND;
`endif

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: idle, single word, back-to-back, pause, mid-word reset, dropped load.
module tb_serial_pattern_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       load = 1'b0;
  logic       pause = 1'b0;
  logic       ready, x, bit_valid, busy, done, found_exp;
  logic       ref_found;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_pattern_tx #(.WIDTH(8), .IDLE_LEVEL(1'b0)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .load      (load),
    .ready     (ready),
    .pause     (pause),
    .x         (x),
    .bit_valid (bit_valid),
    .busy      (busy),
    .done      (done),
    .found_exp (found_exp)
  );

  // Standalone predictor watching the link, checked against the same hand-derived table.
  pattern_predictor u_ref (
    .clk_i       (clk),
    .rst_ni      (reset),
    .bit_valid_i (bit_valid),
    .x_i         (x),
    .found_o     (ref_found)
  );

  task automatic chk(input string tag, input int cyc, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic cyc_check(input string tag, input int cyc, input logic ex, input logic ebv,
                           input logic edn, input logic ebz, input logic erd, input logic efd);
    logic efd_dut;
`ifdef PATTERN_PREDICT_EN
    efd_dut = efd;
`else
    efd_dut = 1'b0;
`endif
    chk({tag, ".x"},         cyc, x,         ex);
    chk({tag, ".bit_valid"}, cyc, bit_valid, ebv);
    chk({tag, ".done"},      cyc, done,      edn);
    chk({tag, ".busy"},      cyc, busy,      ebz);
    chk({tag, ".ready"},     cyc, ready,     erd);
    chk({tag, ".found_exp"}, cyc, found_exp, efd_dut);
    chk({tag, ".ref_found"}, cyc, ref_found, efd);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a word in an idle cycle; it is accepted at the next edge.
  task automatic start_word(input string tag, input logic [7:0] w);
    step();
    load    = 1'b1;
    data_in = w;
    pause   = 1'b0;
    #1;
    chk({tag, ".ready_at_load"}, 0, ready, 1'b1);
  endtask

  // Per-cycle vectors are indexed by cycle-1 (index 0 = first cycle after the load edge).
  task automatic send(input string tag, input int n,
                      input logic [0:19] xs, input logic [0:19] bv, input logic [0:19] dn,
                      input logic [0:19] bz, input logic [0:19] rd, input logic [0:19] fd,
                      input logic [0:19] ld, input logic [0:19] pz, input logic [7:0] nxt);
    for (int k = 0; k < n; k++) begin
      step();
      load    = ld[k];
      data_in = nxt;
      pause   = pz[k];
      #1;
      cyc_check(tag, k + 1, xs[k], bv[k], dn[k], bz[k], rd[k], fd[k]);
    end
    load  = 1'b0;
    pause = 1'b0;
  endtask

  initial begin
    // Reset state while reset is held low.
    step();
    step();
    cyc_check("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    reset = 1'b1;

    // 1: idle for five cycles, pause high in IDLE has no effect.
    send("idle", 5,
         20'b00000_000000000000000, 20'b00000_000000000000000, 20'b00000_000000000000000,
         20'b00000_000000000000000, 20'b11111_000000000000000, 20'b00000_000000000000000,
         20'b00000_000000000000000, 20'b11111_000000000000000, 8'h00);

    // 2: single word A5.
    start_word("a5", 8'hA5);
    send("a5", 9,
         20'b10100101_0_00000000000, 20'b11111111_0_00000000000, 20'b00000001_0_00000000000,
         20'b11111111_0_00000000000, 20'b00000001_1_00000000000, 20'b00110011_0_00000000000,
         20'b00000000_0_00000000000, 20'b00000000_0_00000000000, 8'h00);

    // 3: F0 then 0F loaded during the LSB cycle, no gap.
    start_word("b2b", 8'hF0);
    send("b2b", 17,
         20'b11110000_00001111_0_000, 20'b11111111_11111111_0_000, 20'b00000001_00000001_0_000,
         20'b11111111_11111111_0_000, 20'b00000001_00000001_1_000, 20'b00000000_00000000_0_000,
         20'b00000001_00000000_0_000, 20'b00000000_00000000_0_000, 8'h0F);

    // 4: A5 with pause in cycles 3-4; history carries over from the 0F word (ends 1,1).
    start_word("pause", 8'hA5);
    send("pause", 11,
         20'b10111001010_000000000, 20'b11001111110_000000000, 20'b00000000010_000000000,
         20'b11111111110_000000000, 20'b00000000011_000000000, 20'b00001100110_000000000,
         20'b00000000000_000000000, 20'b00110000000_000000000, 8'h00);

    // 5: reset asserted while bit 4 of FF is on the line.
    start_word("rst", 8'hFF);
    send("rst", 3,
         20'b111_00000000000000000, 20'b111_00000000000000000, 20'b000_00000000000000000,
         20'b111_00000000000000000, 20'b000_00000000000000000, 20'b000_00000000000000000,
         20'b000_00000000000000000, 20'b000_00000000000000000, 8'h00);
    step();
    #1;
    cyc_check("rst.bit4", 4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    cyc_check("rst.abort", 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    cyc_check("rst.held", 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    start_word("w55", 8'h55);
    send("w55", 9,
         20'b01010101_0_00000000000, 20'b11111111_0_00000000000, 20'b00000001_0_00000000000,
         20'b11111111_0_00000000000, 20'b00000001_1_00000000000, 20'b00111111_0_00000000000,
         20'b00000000_0_00000000000, 20'b00000000_0_00000000000, 8'h00);

    // 6: load of 3C pulsed in cycle 3 of C3 is dropped.
    start_word("drop", 8'hC3);
    send("drop", 10,
         20'b11000011_00_0000000000, 20'b11111111_00_0000000000, 20'b00000001_00_0000000000,
         20'b11111111_00_0000000000, 20'b00000001_11_0000000000, 20'b00000000_00_0000000000,
         20'b00100000_00_0000000000, 20'b00000000_00_0000000000, 8'h3C);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
